seq_div_32b16b: RTL and testbench
=================================

// Module: seq_div_32b16b
// PURPOSE
//  Sequential restoring radix-2 divider: DW_N-bit dividend / DW_D-bit divisor -> quotient + remainder.
//  Inverse companion to the 16b multiplier datapath. Retires one quotient bit per cycle through one shared
//  (DW_D+1)-bit trial subtractor. Valid/ready on both sides; sits beside the multiplier in the arithmetic unit.
// PARAMETERS
//  DW_N   32  dividend and quotient width
//  DW_D   16  divisor and remainder width (DW_D <= DW_N)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      operands valid
//  in_ready     out  1      divider can accept operands
//  dividend     in   DW_N   N
//  divisor      in   DW_D   D
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  quotient     out  DW_N   Q
//  remainder    out  DW_D   R
//  div_by_zero  out  1      result is from D==0, qualified by out_valid
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; in_ready=1, out_valid=0; quotient, remainder, div_by_zero=0.
//  - States: IDLE -> CALC -> DONE -> IDLE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  - IDLE: on in_valid&&in_ready at edge k, latch N and D. D!=0: go CALC, cnt=DW_N-1, partial rem P=0.
//    D==0: go DONE directly; out_valid at edge k+1 with Q=all ones, R=N[DW_D-1:0], div_by_zero=1.
//  - CALC, one step per cycle: P'={P,N[MSB]} (DW_D+1 bits); N<<=1; T=P'-{1'b0,D}.
//    If T>=0 (T MSB clear) P=T, shift 1 into Q LSB; else P=P', shift 0. cnt==0 -> DONE.
//  - Latency (unsigned, D!=0): out_valid first high after edge k+DW_N+1 (33 edges at defaults).
//  - DONE: Q, R, div_by_zero held stable while out_valid && !out_ready. Leave DONE on out_valid&&out_ready.
//    New operands are taken next cycle at the earliest (no same-cycle turnaround).
//  - in_valid during CALC/DONE is ignored. The producer must hold its operands until in_ready.
//  - Arithmetic: no overflow possible, Q < 2^DW_N and R < D. R = final P[DW_D-1:0].
//  - Reset during CALC or DONE aborts the op, discards the result and returns to IDLE with the reset values.
// CONFIGURATION
//  SIGNED_DIV_EN defined: operands are two's complement. In IDLE latch |N| and |D| and record the signs.
//    Add state FIX between CALC and DONE (+1 cycle): Q negated if sign(N)^sign(D); R negated if sign(N).
//    Division truncates toward zero; remainder has the sign of the dividend.
//    D==0: Q=all ones, R=N[DW_D-1:0], div_by_zero=1, FIX skipped.
//    N=most-negative, D=-1: Q=most-negative (wraps), R=0, no flag.
//  SIGNED_DIV_EN undefined: unsigned only, no FIX state and no sign logic.
// STRUCTURE
//  Shared package arith_pkg: state enum (IDLE, CALC, FIX, DONE), DW_N/DW_D defaults, and
//    clog2-based counter width constant CNT_W.
//  One sub-module: div_trial_sub. Combinational (DW_D+1)-bit subtractor with operands {P', D}.
//    Outputs difference and borrow. Built as a carry-select split like the existing adders: B inverted, Cin=1.
//  Top holds the FSM, counter, shift registers and output registers.
// TESTING
//  1 N=100, D=7, out_ready=1 -> Q=14, R=2, div_by_zero=0; out_valid first high 33 edges after accept.
//  2 N=0xFFFFFFFF, D=0xFFFF -> Q=0x00010001, R=0. N=5, D=9 -> Q=0, R=5.
//  3 N=0x1234, D=0 -> out_valid 1 edge after accept: Q=0xFFFFFFFF, R=0x1234, div_by_zero=1.
//  4 N=1000, D=10 with out_ready=0 for 5 cycles after out_valid -> Q=100, R=0 held stable.
//    in_ready=0 throughout; in_ready=1 the cycle after out_ready rises.
//  5 N=100, D=7, assert rst at CALC step 10 -> out_valid=0, in_ready=1 immediately.
//    Next op N=9, D=2 -> Q=4, R=1.
//  6 (SIGNED_DIV_EN) N=-100, D=7 -> Q=-14, R=-2 after 34 edges.
//    N=100, D=-7 -> Q=-14, R=2. N=0x80000000, D=-1 -> Q=0x80000000, R=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default widths and counter sizing.
package arith_pkg;

  localparam int unsigned DW_N_DEF = 32;
  localparam int unsigned DW_D_DEF = 16;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_w(DW_N_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor a - b for the restoring divider, carry-select split (b inverted, carry-in 1).
module div_trial_sub #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  localparam int unsigned LW = W / 2;
  localparam int unsigned HW = W - LW;

  logic [LW:0] lo;
  logic [HW:0] hi0;
  logic [HW:0] hi1;
  logic        carry;

  always_comb begin
    lo  = {1'b0, a_i[LW-1:0]} + {1'b0, ~b_i[LW-1:0]} + (LW+1)'(1);
    hi0 = {1'b0, a_i[W-1:LW]} + {1'b0, ~b_i[W-1:LW]};
    hi1 = {1'b0, a_i[W-1:LW]} + {1'b0, ~b_i[W-1:LW]} + (HW+1)'(1);
    carry    = lo[LW] ? hi1[HW] : hi0[HW];
    diff_o   = {(lo[LW] ? hi1[HW-1:0] : hi0[HW-1:0]), lo[LW-1:0]};
    borrow_o = ~carry;
  end

endmodule

// File: rtl/seq_div_32b16b.sv
// Sequential restoring radix-2 divider, one quotient bit per cycle, valid/ready on both sides.
// Define SIGNED_DIV_EN for two's-complement operands (adds a sign-fixup state).
module seq_div_32b16b
  import arith_pkg::*;
#(
  parameter int unsigned DW_N = DW_N_DEF,
  parameter int unsigned DW_D = DW_D_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            div_by_zero
);

  localparam int unsigned CW = (CNT_W > cnt_w(DW_N)) ? CNT_W : cnt_w(DW_N);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [DW_N-1:0] n_q;
  logic [DW_N-1:0] q_q;
  logic [DW_D-1:0] p_q;
  logic [DW_D-1:0] d_q;
  logic            dbz_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [DW_N-1:0] quo_q;
  logic [DW_D-1:0] rem_q;
  logic            dbzo_q;
`ifdef SIGNED_DIV_EN
  logic            sn_q;
  logic            sd_q;
`endif

  logic [DW_D:0]   p_ext;
  logic [DW_D:0]   t_diff;
  logic            t_borrow;
  logic            take;
  logic [DW_D-1:0] p_d;
  logic [DW_N-1:0] q_d;
  logic            diff_msb_unused;

  div_trial_sub #(.W(DW_D + 1)) u_sub (
    .a_i     (p_ext),
    .b_i     ({1'b0, d_q}),
    .diff_o  (t_diff),
    .borrow_o(t_borrow)
  );

  always_comb begin
    p_ext = {p_q, n_q[DW_N-1]};
    take  = ~t_borrow;
    p_d   = take ? t_diff[DW_D-1:0] : p_ext[DW_D-1:0];
    q_d   = {q_q[DW_N-2:0], take};
    diff_msb_unused = t_diff[DW_D];
  end

  // Results land in the output registers one cycle after entering DONE, which
  // gives the fixed accept-to-valid latency for both the zero and non-zero divisor paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      q_q         <= '0;
      p_q         <= '0;
      d_q         <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dbzo_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
      sn_q        <= 1'b0;
      sd_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            cnt_q      <= CW'(DW_N - 1);
`ifdef SIGNED_DIV_EN
            sn_q <= dividend[DW_N-1];
            sd_q <= divisor[DW_D-1];
            n_q  <= dividend[DW_N-1] ? -dividend : dividend;
            d_q  <= divisor[DW_D-1] ? -divisor : divisor;
`else
            n_q  <= dividend;
            d_q  <= divisor;
`endif
            if (divisor == '0) begin
              state_q <= DONE;
              q_q     <= '1;
              p_q     <= dividend[DW_D-1:0];
              dbz_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              q_q     <= '0;
              p_q     <= '0;
              dbz_q   <= 1'b0;
            end
          end
        end
        CALC: begin
          n_q <= n_q << 1;
          p_q <= p_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
`ifdef SIGNED_DIV_EN
            state_q <= FIX;
`else
            state_q <= DONE;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
`ifdef SIGNED_DIV_EN
        FIX: begin
          q_q     <= (sn_q ^ sd_q) ? -q_q : q_q;
          p_q     <= sn_q ? -p_q : p_q;
          state_q <= DONE;
        end
`endif
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            quo_q       <= q_q;
            rem_q       <= p_q;
            dbzo_q      <= dbz_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_seq_div_32b16b.sv
// Scoreboard bench for seq_div_32b16b: driver pushes model results, monitor checks each result on out_valid.
module tb_seq_div_32b16b;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dbz;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        in_ready, out_valid, div_by_zero;
  logic [31:0] quotient;
  logic [15:0] remainder;

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_tot = 0;
  bit          rnd_ready = 1'b0;
  exp_t        sb[$];

  seq_div_32b16b #(.DW_N(32), .DW_D(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [31:0] n, input logic [15:0] d);
    exp_t e;
`ifdef SIGNED_DIV_EN
    longint sn, sd, qq, rr;
`endif
    e.acc = 0;
    if (d == 16'd0) begin
      e.q = '1; e.r = n[15:0]; e.dbz = 1'b1; e.lat = 1;
    end else begin
`ifdef SIGNED_DIV_EN
      sn = longint'($signed(n));
      sd = longint'($signed(d));
      qq = sn / sd;
      rr = sn % sd;
      e.q = qq[31:0]; e.r = rr[15:0]; e.lat = 34;
`else
      e.q = n / {16'd0, d};
      e.r = 16'(n % {16'd0, d});
      e.lat = 33;
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] n, input logic [15:0] d, input bit push);
    int unsigned t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tot++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", t);
      return;
    end
    dividend = n;
    divisor  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    e = model(n, d);
    e.acc = cyc;
    if (push) sb.push_back(e);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
  endtask

  // Monitor: compare each result when out_valid first rises
  initial begin
    exp_t e;
    logic ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_result: got q=0x%0h with no result expected", quotient);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.dbz);
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    int unsigned t;
    bit bad_ir;
    logic [31:0] n;
    logic [15:0] d;
    int unsigned sel;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    issue(32'd100, 16'd7, 1);
    issue(32'hFFFF_FFFF, 16'hFFFF, 1);
    issue(32'd5, 16'd9, 1);
    issue(32'h1234, 16'd0, 1);

    // Output stall: result must hold while out_ready is low
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    out_ready = 1'b0;
    issue(32'd1000, 16'd10, 1);
    bad_ir = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin
      if (in_ready) bad_ir = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", out_valid, 1);
    repeat (5) begin
      chk("stall_q_hold", quotient, 32'd100);
      chk("stall_r_hold", remainder, 16'd0);
      chk("stall_valid_hold", out_valid, 1);
      if (in_ready) bad_ir = 1'b1;
      @(negedge clk);
    end
    chk("in_ready_low_busy", bad_ir, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_ack", in_ready, 1);
    chk("valid_low_after_ack", out_valid, 0);

    // Reset mid-calculation aborts the operation
    issue(32'd100, 16'd7, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd9, 16'd2, 1);

`ifdef SIGNED_DIV_EN
    issue(32'(-100), 16'd7, 1);
    issue(32'd100, 16'(-7), 1);
    issue(32'h8000_0000, 16'hFFFF, 1);
    issue(32'h8000_0000, 16'd0, 1);
`endif

    // Randomised operands with random output back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      n = $urandom;
      if (sel == 7) n = 32'($urandom_range(0, 50));
      if (sel == 0) d = 16'd0;
      else if (sel < 3) d = 16'($urandom_range(1, 15));
      else d = 16'($urandom);
      issue(n, d, 1);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    t = 0;
    while ((sb.size() != 0 || !in_ready) && t < 500) begin @(negedge clk); t++; end
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
